// File: rtl/game_ctrl.sv
// Frame-synchronised game-state controller for the VGA runner: run/pause/over
// sequencing, gated obstacle collision, lives with post-hit immunity, score and speed.
module game_ctrl #(
  parameter int N_OBST        = 4,
  parameter int SCORE_W       = 16,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SPEED_W       = 4,
  parameter int SPEED_STEP    = 256,
  parameter int SPEED_MAX     = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               vs,
  input  logic               start,
  input  logic               pause,
  input  logic               px_player,
  input  logic [N_OBST-1:0]  px_obst,
  input  logic [N_OBST-1:0]  obst_en,
  output logic [2:0]         state,
  output logic               running,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [SPEED_W-1:0] speed,
  output logic               hit_pulse,
  output logic [N_OBST-1:0]  hit_src,
  output logic               invuln
);

  localparam int STEP_W = $clog2(SPEED_STEP + 1);
  localparam int INV_W  = $clog2(INVULN_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [2:0]          lives_q, lives_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [INV_W-1:0]    inv_q, inv_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic [N_OBST-1:0]   hit_src_q, hit_src_d;
  logic                pause_pend_q, pause_pend_d;
  logic                resume_pend_q, resume_pend_d;
  logic                vs_q, start_q, pause_q;

  logic                frame_tick, start_rise, pause_rise, coll, accept;
  logic [N_OBST-1:0]   coll_vec;
  logic [STEP_W-1:0]   step_inc;

  assign frame_tick = vs_q & ~vs;
  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;
  assign coll_vec   = px_obst & obst_en & {N_OBST{px_player}};
  assign coll       = |coll_vec;
  assign accept     = coll & (inv_q == '0);
  assign step_inc   = step_q + STEP_W'(1);

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    lives_d       = lives_q;
    speed_d       = speed_q;
    step_d        = step_q;
    inv_d         = inv_q;
    hit_pulse_d   = 1'b0;
    hit_src_d     = hit_src_q;
    pause_pend_d  = pause_pend_q;
    resume_pend_d = resume_pend_q;

    case (state_q)
      S_IDLE: if (start_rise) state_d = S_ARMED;

      S_ARMED: if (frame_tick) begin
        state_d       = S_RUN;
        score_d       = '0;
        lives_d       = 3'(LIVES);
        speed_d       = SPEED_W'(1);
        step_d        = '0;
        inv_d         = '0;
        hit_src_d     = '0;
        pause_pend_d  = 1'b0;
        resume_pend_d = 1'b0;
      end

      S_RUN: begin
        if (frame_tick) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          if (step_inc == STEP_W'(SPEED_STEP)) begin
            step_d = '0;
            if (speed_q != SPEED_W'(SPEED_MAX)) speed_d = speed_q + SPEED_W'(1);
          end else begin
            step_d = step_inc;
          end
          if (inv_q != '0) inv_d = inv_q - INV_W'(1);
        end
        if (pause_rise) pause_pend_d = 1'b1;
        // A hit in the pause-applying cycle is resolved first; a fatal one wins outright.
        if (accept && lives_q <= 3'd1) begin
          hit_pulse_d  = 1'b1;
          hit_src_d    = coll_vec;
          lives_d      = '0;
          state_d      = S_OVER;
          pause_pend_d = 1'b0;
        end else begin
          if (accept) begin
            hit_pulse_d = 1'b1;
            hit_src_d   = coll_vec;
            lives_d     = lives_q - 3'd1;
            inv_d       = INV_W'(INVULN_FRAMES);
          end
          if (frame_tick && pause_pend_q) begin
            state_d       = S_PAUSE;
            pause_pend_d  = 1'b0;
            resume_pend_d = 1'b0;
          end
        end
      end

      S_PAUSE: begin
        if (pause_rise) resume_pend_d = 1'b1;
        if (frame_tick && resume_pend_q) begin
          state_d       = S_RUN;
          resume_pend_d = 1'b0;
        end
      end

      S_OVER: if (start_rise) state_d = S_ARMED;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      score_q       <= '0;
      lives_q       <= 3'(LIVES);
      speed_q       <= SPEED_W'(1);
      step_q        <= '0;
      inv_q         <= '0;
      hit_pulse_q   <= 1'b0;
      hit_src_q     <= '0;
      pause_pend_q  <= 1'b0;
      resume_pend_q <= 1'b0;
      vs_q          <= 1'b1;
      start_q       <= 1'b0;
      pause_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      speed_q       <= speed_d;
      step_q        <= step_d;
      inv_q         <= inv_d;
      hit_pulse_q   <= hit_pulse_d;
      hit_src_q     <= hit_src_d;
      pause_pend_q  <= pause_pend_d;
      resume_pend_q <= resume_pend_d;
      vs_q          <= vs;
      start_q       <= start;
      pause_q       <= pause;
    end
  end

  assign state     = state_q;
  assign running   = (state_q == S_RUN);
  assign score     = score_q;
  assign lives     = lives_q;
  assign speed     = speed_q;
  assign hit_pulse = hit_pulse_q;
  assign hit_src   = hit_src_q;
  assign invuln    = (inv_q != '0);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a per-cycle vector table from reset, then
// hand-written multi-frame sequences for speed, immunity, game-over and reset.
module tb_game_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, vs, start, pause, px_player;
  logic [3:0]  px_obst, obst_en;
  logic [2:0]  state, lives;
  logic        running, hit_pulse, invuln;
  logic [15:0] score;
  logic [3:0]  speed, hit_src;

  int tests  = 0;
  int failed = 0;

  game_ctrl #(
    .N_OBST(4), .SCORE_W(16), .LIVES(3), .INVULN_FRAMES(60),
    .SPEED_W(4), .SPEED_STEP(256), .SPEED_MAX(15)
  ) dut (
    .CLK(CLK), .RESET(RESET), .vs(vs), .start(start), .pause(pause),
    .px_player(px_player), .px_obst(px_obst), .obst_en(obst_en),
    .state(state), .running(running), .score(score), .lives(lives),
    .speed(speed), .hit_pulse(hit_pulse), .hit_src(hit_src), .invuln(invuln)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        vs, st, pa, pp;
    logic [3:0]  po, oe;
    logic [2:0]  e_state, e_lives;
    logic [15:0] e_score;
    logic        e_hp, e_inv;
    logic [3:0]  e_src;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one clock's worth of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic st, input logic pa,
                     input logic pp, input logic [3:0] po, input logic [3:0] oe);
    vs = v; start = st; pause = pa; px_player = pp; px_obst = po; obst_en = oe;
    @(posedge CLK); #1;
  endtask

  task automatic idle(); cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0); endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      repeat (3) idle();
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; idle(); RESET = 1'b0;
  endtask

  task automatic begin_game();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    idle();
    frames(1);
  endtask

  task automatic hit_cycle();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 4'h4);
  endtask

  task automatic chk_core(input string tag, input logic [2:0] st, input logic [2:0] lv,
                          input logic [15:0] sc);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".lives"}, 32'(lives), 32'(lv));
    chk({tag, ".score"}, 32'(score), 32'(sc));
  endtask

  initial begin
    //        vs st pa pp po    oe     state lives score  hp inv src
    tbl[0]  = '{1, 0, 0, 0, 4'h0, 4'h0, 3'd0, 3'd3, 16'd0, 0, 0, 4'h0};
    tbl[1]  = '{1, 1, 0, 0, 4'h0, 4'h0, 3'd1, 3'd3, 16'd0, 0, 0, 4'h0};
    tbl[2]  = '{1, 1, 0, 0, 4'h0, 4'h0, 3'd1, 3'd3, 16'd0, 0, 0, 4'h0};
    tbl[3]  = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd2, 3'd3, 16'd0, 0, 0, 4'h0};
    tbl[4]  = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd2, 3'd3, 16'd0, 0, 0, 4'h0};
    tbl[5]  = '{1, 0, 0, 0, 4'h0, 4'h0, 3'd2, 3'd3, 16'd0, 0, 0, 4'h0};
    tbl[6]  = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd2, 3'd3, 16'd1, 0, 0, 4'h0};
    tbl[7]  = '{1, 0, 0, 1, 4'h2, 4'hD, 3'd2, 3'd3, 16'd1, 0, 0, 4'h0};
    tbl[8]  = '{1, 0, 0, 1, 4'h4, 4'h4, 3'd2, 3'd2, 16'd1, 1, 1, 4'h4};
    tbl[9]  = '{1, 0, 0, 1, 4'h4, 4'h4, 3'd2, 3'd2, 16'd1, 0, 1, 4'h4};
    tbl[10] = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd2, 3'd2, 16'd2, 0, 1, 4'h4};
    tbl[11] = '{1, 0, 1, 0, 4'h0, 4'h0, 3'd2, 3'd2, 16'd2, 0, 1, 4'h4};
    tbl[12] = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd3, 3'd2, 16'd3, 0, 1, 4'h4};
    tbl[13] = '{1, 0, 0, 1, 4'h4, 4'h4, 3'd3, 3'd2, 16'd3, 0, 1, 4'h4};
    tbl[14] = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd3, 3'd2, 16'd3, 0, 1, 4'h4};
    tbl[15] = '{1, 0, 1, 0, 4'h0, 4'h0, 3'd3, 3'd2, 16'd3, 0, 1, 4'h4};
    tbl[16] = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd2, 3'd2, 16'd3, 0, 1, 4'h4};
    tbl[17] = '{1, 1, 0, 0, 4'h0, 4'h0, 3'd2, 3'd2, 16'd3, 0, 1, 4'h4};
    tbl[18] = '{0, 0, 0, 0, 4'h0, 4'h0, 3'd2, 3'd2, 16'd4, 0, 1, 4'h4};

    RESET = 1'b1; vs = 1'b1; start = 1'b0; pause = 1'b0;
    px_player = 1'b0; px_obst = 4'h0; obst_en = 4'h0;
    repeat (2) begin @(posedge CLK); #1; end
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.lives", 32'(lives), 32'd3);
    chk("rst.score", 32'(score), 32'd0);
    chk("rst.speed", 32'(speed), 32'd1);
    chk("rst.invuln", 32'(invuln), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].vs, tbl[i].st, tbl[i].pa, tbl[i].pp, tbl[i].po, tbl[i].oe);
      chk_core($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_lives, tbl[i].e_score);
      chk($sformatf("vec%0d.hit_pulse", i), 32'(hit_pulse), 32'(tbl[i].e_hp));
      chk($sformatf("vec%0d.invuln", i), 32'(invuln), 32'(tbl[i].e_inv));
      chk($sformatf("vec%0d.hit_src", i), 32'(hit_src), 32'(tbl[i].e_src));
      chk($sformatf("vec%0d.running", i), 32'(running), 32'(tbl[i].e_state == 3'd2));
    end

    // Speed ramp and saturation.
    do_reset();
    begin_game();
    chk_core("spd0", 3'd2, 3'd3, 16'd0);
    frames(255);
    chk("spd255.speed", 32'(speed), 32'd1);
    frames(1);
    chk("spd256.speed", 32'(speed), 32'd2);
    frames(44);
    chk("spd300.score", 32'(score), 32'd300);
    chk("spd300.speed", 32'(speed), 32'd2);
    frames(3284);
    chk("spd3584.speed", 32'(speed), 32'd15);
    frames(300);
    chk("spdsat.speed", 32'(speed), 32'd15);
    chk("spdsat.score", 32'(score), 32'd3884);

    // Immunity window, three hits to game over, restart.
    do_reset();
    begin_game();
    hit_cycle();
    chk("h1.pulse", 32'(hit_pulse), 32'd1);
    chk("h1.lives", 32'(lives), 32'd2);
    idle();
    chk("h1.pulse_off", 32'(hit_pulse), 32'd0);
    frames(59);
    chk("h1.inv59", 32'(invuln), 32'd1);
    hit_cycle();
    chk("h1.ignored_pulse", 32'(hit_pulse), 32'd0);
    chk("h1.ignored_lives", 32'(lives), 32'd2);
    frames(1);
    chk("h1.inv60", 32'(invuln), 32'd0);
    hit_cycle();
    chk("h2.pulse", 32'(hit_pulse), 32'd1);
    chk("h2.lives", 32'(lives), 32'd1);
    frames(60);
    hit_cycle();
    chk("h3.pulse", 32'(hit_pulse), 32'd1);
    chk_core("h3", 3'd4, 3'd0, 16'd120);
    frames(5);
    chk_core("over", 3'd4, 3'd0, 16'd120);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("restart.state", 32'(state), 32'd1);
    idle();
    frames(1);
    chk_core("restart", 3'd2, 3'd3, 16'd0);
    chk("restart.hit_src", 32'(hit_src), 32'd0);
    chk("restart.speed", 32'(speed), 32'd1);

    // Fatal hit on the same frame_tick that would apply a pending pause.
    do_reset();
    begin_game();
    hit_cycle();
    frames(60);
    hit_cycle();
    chk("pf.lives1", 32'(lives), 32'd1);
    frames(60);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h1);
    chk("pf.state", 32'(state), 32'd4);
    chk("pf.lives", 32'(lives), 32'd0);
    chk("pf.hit_src", 32'(hit_src), 32'd1);
    frames(2);
    chk("pf.stay_over", 32'(state), 32'd4);

    // Reset during PAUSE beats simultaneous start/pause/frame events.
    do_reset();
    begin_game();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    frames(1);
    chk_core("pz", 3'd3, 3'd3, 16'd1);
    frames(10);
    chk("pz.frozen", 32'(score), 32'd1);
    RESET = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
    RESET = 1'b0;
    chk_core("pzrst", 3'd0, 3'd3, 16'd0);
    chk("pzrst.speed", 32'(speed), 32'd1);
    chk("pzrst.hit_pulse", 32'(hit_pulse), 32'd0);
    chk("pzrst.hit_src", 32'(hit_src), 32'd0);
    chk("pzrst.invuln", 32'(invuln), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Frame-synchronised game-state controller for the VGA runner game. It replaces the single-bit running/stopped flag with a five-state machine. It adds multi-channel obstacle collision with per-channel enables, a lives counter with post-hit invulnerability, a frame-based score, a speed level derived from the score, and pause/resume. All state changes that affect rendering are applied at vertical blanking; sprite/obstacle blocks consume state, speed and score.

Parameters:
N_OBST, 4, number of obstacle pixel channels
SCORE_W, 16, score width (saturating)
LIVES, 3, lives loaded at game start (1..7)
INVULN_FRAMES, 60, frames of collision immunity after a non-fatal hit
SPEED_W, 4, speed level width
SPEED_STEP, 256, running frames per speed increment
SPEED_MAX, 15, speed saturation value (must be < 2^SPEED_W)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
vs  in  1  VGA vertical sync, low during blanking
start  in  1  start button, active-high level (already debounced)
pause  in  1  pause button, active-high level
px_player  in  1  player sprite pixel active at current scan position
px_obst  in  N_OBST  obstacle pixel per channel
obst_en  in  N_OBST  per-channel collision enable
state  out  3  0 IDLE, 1 ARMED, 2 RUN, 3 PAUSE, 4 OVER
running  out  1  state==RUN
score  out  SCORE_W  frames survived
lives  out  3  remaining lives
speed  out  SPEED_W  current speed level
hit_pulse  out  1  one-cycle pulse on accepted collision
hit_src  out  N_OBST  channels colliding at the accepted hit; held until next hit or game start
invuln  out  1  immunity window active

Behaviour:
- Reset: state=IDLE, score=0, lives=LIVES, speed=1, hit_pulse=0, hit_src=0, invuln=0, internal counters and latches 0, vs_q=1, start_q=pause_q=0.
- frame_tick = vs_q & ~vs: one CLK pulse per frame, one cycle after vs falls.
- start_rise / pause_rise = level & ~registered level: one pulse per press; a held button never retriggers.
- coll = |(px_obst & obst_en) & px_player, evaluated combinationally each cycle.
- IDLE: start_rise -> ARMED.
- ARMED: on frame_tick -> RUN. In that same cycle: score=0, lives=LIVES, speed=1, step counter=0, invuln counter=0, hit_src=0.
- RUN:
  - frame_tick: score+1, saturating at all-ones. Step counter+1; on reaching SPEED_STEP it clears and speed+1, saturating at SPEED_MAX.
  - Invuln counter decrements on frame_tick while nonzero; invuln = (counter != 0).
  - coll with invuln=0 accepts a hit that cycle: hit_pulse=1 next cycle, hit_src registered.
    - If lives>1: lives-1, invuln counter=INVULN_FRAMES.
    - If lives==1: lives=0, -> OVER.
  - Collisions while invuln=1 are ignored, with no pulse. Only one hit is accepted per immunity window.
  - pause_rise sets pause_pend. The next frame_tick with pause_pend=1 -> PAUSE and clears pause_pend.
  - Collision precedence: an accepted hit in the same cycle as that frame_tick is processed first. If it is fatal, go to OVER and drop pause_pend.
- PAUSE: score, speed, invuln and lives frozen; collisions ignored. pause_rise sets resume_pend; the next frame_tick -> RUN.
- OVER: all counters frozen, outputs hold final values. start_rise -> ARMED.
- start_rise in ARMED, RUN or PAUSE is ignored.
- pause_rise in IDLE, ARMED or OVER is ignored.
- RESET mid-game takes priority over every event in the same cycle.

Test Plan:
- Reset, start pulse, one vs falling edge -> state 0→1→2 within 2 cycles of frame_tick; lives=3, score=0, speed=1.
- RUN for 300 frames, no collision -> score=300, speed=2 (increment at frame 256), step counter=44.
- Overlap px_player & px_obst[2] with obst_en=4'b0100 -> one hit_pulse, hit_src=4'b0100, lives=2, invuln=1. Repeated overlaps within the next 59 frames give no pulse; invuln clears after 60 frames.
- Overlap on a disabled channel (obst_en[1]=0, px_obst[1]=1) -> no hit, lives unchanged.
- Three spaced hits -> lives 3→2→1→0, state=OVER. score frozen; a start pulse -> ARMED, and the next frame -> RUN with lives=3, score=0.
- pause pulse mid-frame -> PAUSE at the next frame_tick, score constant over 10 frames. A second pause pulse -> RUN at the following frame. Fatal hit on the same cycle as the pause-applying frame_tick -> OVER. RESET asserted during PAUSE -> all reset values next cycle.
